// File: rtl/xor_stream_checksum.sv
// xor_stream_checksum
// Frames a stream of WIDTH-bit words and XOR-reduces each frame. When the
// last word of a frame is accepted, the checksum, its parity, the saturating
// word count and an overflow flag are held on a valid/ready result port.
// The result is held until the consumer takes it; input is blocked meanwhile.
module xor_stream_checksum #(
   parameter  int WIDTH   = 16,
   parameter  int MAX_LEN = 255,
   localparam int CW      = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_parity,
   output logic [CW-1:0]    out_count,
   output logic             out_overflow
);

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);
   localparam logic [CW-1:0] ONE_CNT = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   // Holds in_ready low until the first clock edge after reset release.
   logic             rdy_en_q, rdy_en_d;

   logic             accept;
   logic             consume;

   // Count increment that sticks at MAX_LEN instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      if (c == MAX_CNT) begin
         return c;
      end
      return c + ONE_CNT;
   endfunction

   // True when one more accepted word would exceed the countable length.
   function automatic logic sat_hit(input logic [CW-1:0] c);
      return (c == MAX_CNT);
   endfunction

   assign accept  = in_valid && in_ready;
   assign consume = out_valid && out_ready;

   // State and datapath registers; reset discards any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         rdy_en_q <= rdy_en_d;
      end
   end

   // Next-state selection: frame start, accumulate, then hold the result.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = in_last ? S_HOLD : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (accept && in_last) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (consume) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Accumulator, counter and overflow update; the first word of a frame
   // loads the accumulator so nothing leaks from the previous frame.
   always_comb begin
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      rdy_en_d = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               acc_d = in_data;
               cnt_d = ONE_CNT;
               ovf_d = 1'b0;
            end
         end
         S_ACCUM: begin
            if (accept) begin
               acc_d = acc_q ^ in_data;
               cnt_d = sat_inc(cnt_q);
               ovf_d = ovf_q | sat_hit(cnt_q);
            end
         end
         S_HOLD: begin
            if (consume) begin
               acc_d = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
            end
         end
         default: begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
         end
      endcase
   end

   // Outputs decoded from state only; result fields are zero unless valid.
   always_comb begin
      in_ready     = rdy_en_q && (state_q != S_HOLD);
      out_valid    = (state_q == S_HOLD);
      out_sum      = '0;
      out_parity   = 1'b0;
      out_count    = '0;
      out_overflow = 1'b0;
      if (state_q == S_HOLD) begin
         out_sum      = acc_q;
         out_parity   = ^acc_q;
         out_count    = cnt_q;
         out_overflow = ovf_q;
      end
   end

endmodule

// File: tb/tb_xor_stream_checksum.sv
// Self-checking bench for xor_stream_checksum (WIDTH=16, MAX_LEN=4).
// A frame-level reference model predicts every output each cycle; directed
// frames also compare against hand-computed literals.
module tb_xor_stream_checksum;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_parity;
   logic [2:0]  out_count;
   logic        out_overflow;

   int tests = 0;
   int fails = 0;

   logic or_fixed = 1'b1;
   logic rnd_or   = 1'b0;
   logic rnd_bit  = 1'b0;
   logic chk_en   = 1'b0;

   always #5 clk = ~clk;

   assign out_ready = rnd_or ? rnd_bit : or_fixed;

   always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

   xor_stream_checksum #(.WIDTH(16), .MAX_LEN(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_parity(out_parity),
      .out_count(out_count), .out_overflow(out_overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   logic [15:0] frame[$];
   logic        exp_valid = 1'b0;
   logic        exp_rdy   = 1'b0;
   logic        rdy_en    = 1'b0;
   logic [15:0] res_sum   = '0;
   logic [2:0]  res_cnt   = '0;
   logic        res_ovf   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame.delete();
         exp_valid = 1'b0;
         rdy_en    = 1'b0;
      end else begin
         if (exp_valid) begin
            if (out_ready) exp_valid = 1'b0;
         end else if (rdy_en && in_valid) begin
            frame.push_back(in_data);
            if (in_last) begin
               logic [15:0] s;
               int n;
               s = '0;
               foreach (frame[i]) s ^= frame[i];
               n = frame.size();
               res_sum   = s;
               res_cnt   = (n > 4) ? 3'd4 : 3'(n);
               res_ovf   = (n > 4);
               exp_valid = 1'b1;
               frame.delete();
            end
         end
         rdy_en = 1'b1;
      end
      exp_rdy = rdy_en && !exp_valid;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_out_valid", 32'(out_valid), 32'(exp_valid));
         chk("cyc_in_ready", 32'(in_ready), 32'(exp_rdy));
         chk("cyc_out_sum", 32'(out_sum), exp_valid ? 32'(res_sum) : 32'd0);
         chk("cyc_out_parity", 32'(out_parity), exp_valid ? 32'(^res_sum) : 32'd0);
         chk("cyc_out_count", 32'(out_count), exp_valid ? 32'(res_cnt) : 32'd0);
         chk("cyc_out_overflow", 32'(out_overflow), exp_valid ? 32'(res_ovf) : 32'd0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [15:0] d, input logic l);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_last  = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_result(input string tag, input int maxc, input logic [15:0] es,
                              input logic ep, input logic [2:0] ec, input logic eo);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_sum"}, 32'(out_sum), 32'(es));
      chk({tag, "_parity"}, 32'(out_parity), 32'(ep));
      chk({tag, "_count"}, 32'(out_count), 32'(ec));
      chk({tag, "_overflow"}, 32'(out_overflow), 32'(eo));
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_out_count", 32'(out_count), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("rel_in_ready_high", 32'(in_ready), 32'd1);
      chk_en = 1'b1;

      // 1: single-word frame
      or_fixed = 1'b1;
      send(16'hA5A5, 1'b1);
      wait_result("t1", 0, 16'hA5A5, 1'b0, 3'd1, 1'b0);
      chk("t1_in_ready", 32'(in_ready), 32'd0);

      // 2: three-word frame, result lasts one cycle
      send(16'h00FF, 1'b0);
      send(16'h0F0F, 1'b0);
      send(16'hF000, 1'b1);
      wait_result("t2", 0, 16'hFFF0, 1'b0, 3'd3, 1'b0);
      chk("t2_model_sum", 32'(res_sum), 32'h0000FFF0);
      @(negedge clk);
      chk("t2_valid_drop", 32'(out_valid), 32'd0);

      // 3: back-pressure in HOLD
      or_fixed = 1'b0;
      send(16'h5A5A, 1'b1);
      wait_result("t3", 0, 16'h5A5A, 1'b0, 3'd1, 1'b0);
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_valid", 32'(out_valid), 32'd1);
         chk("t3_hold_sum", 32'(out_sum), 32'h00005A5A);
         chk("t3_hold_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      or_fixed = 1'b1;
      @(negedge clk);
      chk("t3_release_valid", 32'(out_valid), 32'd0);
      chk("t3_release_ready", 32'(in_ready), 32'd1);

      // 4: overflow, then clean next frame
      for (int i = 0; i < 6; i++) send(16'h0001, (i == 5));
      wait_result("t4", 0, 16'h0000, 1'b0, 3'd4, 1'b1);
      chk("t4_model_ovf", 32'(res_ovf), 32'd1);
      send(16'h0007, 1'b1);
      wait_result("t4b", 0, 16'h0007, 1'b1, 3'd1, 1'b0);

      // 5: back-to-back identical frames
      send(16'h1234, 1'b1);
      wait_result("t5a", 0, 16'h1234, 1'b1, 3'd1, 1'b0);
      send(16'h1234, 1'b1);
      wait_result("t5b", 0, 16'h1234, 1'b1, 3'd1, 1'b0);

      // 6: reset mid-frame
      send(16'h0011, 1'b0);
      send(16'h0022, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(16'h0003, 1'b1);
      wait_result("t6", 2, 16'h0003, 1'b0, 3'd1, 1'b0);

      // Randomized frames with random back-pressure and input gaps
      rnd_or = 1'b1;
      for (int f = 0; f < 200; f++) begin
         int len;
         len = $urandom_range(1, 7);
         for (int b = 0; b < len; b++) begin
            send(16'($urandom), (b == len - 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      rnd_or   = 1'b0;
      or_fixed = 1'b1;
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
